hps_spi_bridge: RTL and testbench
=================================

// Module: hps_spi_bridge
// PURPOSE
//  Parametrised HPS<->FPGA SPI bridge; successor to the fixed 16-bit HPS interface block.
//  - Integrated mode-0 SPI slave, oversampled in sys_clk: no separate SPI core.
//  - WORD_W-bit words, MSB first; multiple words per chip-select frame.
//  - Received words are buffered in an RX FIFO with valid/ready drain.
//  - The TX word is sampled at every word boundary.
//  - Status bits are packed into gp_out above the FIFO head.
// PARAMETERS
//  WORD_W      16  SPI word width, bits (>=8)
//  FIFO_DEPTH  4   RX FIFO entries, power of 2, >=2
//  STATUS_W    3   status bits packed into gp_out
//  GP_W        32  gp_out width; WORD_W+STATUS_W+2 <= GP_W, else elaboration error
// PORTS
//  sys_clk     in   1         system clock; must be >= 8x spi_clk
//  reset_n     in   1         asynchronous active-low reset
//  spi_clk     in   1         SPI clock from HPS (async)
//  spi_cs      in   1         chip select, active low (async)
//  spi_mosi    in   1         SPI data from HPS (async)
//  spi_miso    out  1         SPI data to HPS
//  tx_data     in   WORD_W    word returned to HPS during the next word slot
//  rx_data     out  WORD_W    RX FIFO head
//  rx_valid    out  1         FIFO non-empty
//  rx_ready    in   1         pop head when rx_valid&rx_ready
//  io_strobe   out  1         1-cycle pulse per word accepted into FIFO
//  frame_act   out  1         synchronised CS asserted
//  overflow    out  1         sticky: a word was dropped on a full FIFO
//  ovf_clr     in   1         clears overflow
//  status      in   STATUS_W  status bits
//  gp_out      out  GP_W      {0.., overflow, frame_act, status, rx_data}
// BEHAVIOUR
//  - Reset: all outputs 0; FIFO empty; bit_cnt=0; shift registers 0. Reset is async assert.
//  - Synchronisation: spi_clk, spi_cs and spi_mosi each pass through 2 flops. A third flop
//    on spi_clk and spi_cs gives edge detects rise_e, fall_e, cs_fall_e, cs_rise_e.
//  - Frame start (cs_fall_e): tx_sh<=tx_data, bit_cnt<=0, frame_act<=1.
//    spi_miso = tx_sh[MSB] whenever frame_act=1; otherwise 0.
//  - rise_e while frame_act: rx_sh<={rx_sh,mosi_s}, bit_cnt++.
//    On the rise_e that completes bit WORD_W-1: word={rx_sh[WORD_W-2:0],mosi_s} is pushed;
//    bit_cnt<=0; reload_pend<=1.
//  - fall_e while frame_act:
//    - reload_pend=1: tx_sh<=tx_data (fresh sample), reload_pend<=0.
//    - otherwise: tx_sh<=tx_sh<<1.
//    - fall_e before the first rise_e of a frame is ignored (mode 0: MSB already present).
//  - Push latency: io_strobe is high the cycle after the completing rise_e. rx_valid rises
//    in the same cycle when the FIFO was empty (first-word fall-through).
//  - FIFO: pop when rx_valid&rx_ready.
//    - Push on full: word dropped, no io_strobe, overflow<=1.
//    - Push and pop in the same cycle on full: pop first, push accepted, count unchanged.
//    - Pop on empty: ignored.
//    - Pointers wrap mod FIFO_DEPTH.
//  - ovf_clr: clears overflow. Simultaneous ovf_clr and a new overflow: overflow stays 1.
//  - cs_rise_e mid-word: partial word discarded, no push, bit_cnt<=0, reload_pend<=0,
//    frame_act<=0. FIFO contents are kept.
//  - Glitch: cs_fall_e and cs_rise_e cannot coincide (single synchroniser). rise_e/fall_e
//    while frame_act=0 are ignored.
//  - gp_out is registered from internal state, so it reflects the same cycle as rx_data.
// STRUCTURE
//  - Shared package hps_if_pkg: GP_W default, gp_out field offsets
//    (GP_STATUS_LSB=WORD_W, GP_FRAME_BIT, GP_OVF_BIT), SPI mode constant.
//  - Sub-module hps_spi_rx_fifo (WORD_W, FIFO_DEPTH): push/pop/full/empty, FWFT.
//  - Top holds synchronisers, edge detect, bit counter, shift registers, overflow, gp_out packing.
// TESTING
//  1 Reset: hold reset_n=0 mid-frame -> all outputs 0, spi_miso=0. Release -> idle,
//    rx_valid=0.
//  2 One frame, WORD_W=16, spi_clk=sys_clk/10, MOSI 0xA5C3, tx_data=0x1234
//    -> MISO bits = 0x1234 MSB first; one io_strobe; rx_data=0xA5C3, rx_valid=1.
//  3 Three words in one CS, tx_data changed to 0xBEEF after word 1 completes
//    -> MISO word 2 = 0xBEEF; FIFO holds 3 entries in order; 3 io_strobes.
//  4 rx_ready=0, FIFO_DEPTH=4, send 5 words -> 4 strobes, overflow=1, FIFO holds words 1-4.
//    ovf_clr -> overflow=0.
//  5 CS deasserted after 9 bits -> no push, no strobe. Next frame word 0x0F0F received intact.
//  6 Full FIFO with rx_ready=1 in the same cycle as a push -> word accepted, count stays 4,
//    overflow=0.

Source files
------------

// File: rtl/hps_if_pkg.sv
// Shared definitions for the HPS<->FPGA SPI bridge: gp_out field layout,
// default widths and the supported SPI mode.
package hps_if_pkg;

    localparam int unsigned GP_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        SPI_MODE_0 = 2'd0,
        SPI_MODE_1 = 2'd1,
        SPI_MODE_2 = 2'd2,
        SPI_MODE_3 = 2'd3
    } spi_mode_e;

    // The bridge samples MOSI on rising SCK and shifts MISO on falling SCK.
    localparam spi_mode_e SPI_MODE = SPI_MODE_0;

    // gp_out layout: {0.., overflow, frame_act, status, rx_data}
    function automatic int unsigned gp_status_lsb(input int unsigned word_w);
        return word_w;
    endfunction

    function automatic int unsigned gp_frame_bit(input int unsigned word_w,
                                                 input int unsigned status_w);
        return word_w + status_w;
    endfunction

    function automatic int unsigned gp_ovf_bit(input int unsigned word_w,
                                               input int unsigned status_w);
        return word_w + status_w + 1;
    endfunction

endpackage

// File: rtl/hps_spi_rx_fifo.sv
// RX word FIFO, first-word fall-through. The head is registered and a
// look-ahead copy (head_nxt) is exported so the parent can pack it into
// other registered outputs in the same cycle. On a full FIFO a simultaneous
// pop makes room for the push.
module hps_spi_rx_fifo #(
    parameter int unsigned WORD_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [WORD_W-1:0] push_data,
    input  logic              pop_req,
    output logic [WORD_W-1:0] head,
    output logic [WORD_W-1:0] head_nxt,
    output logic              valid,
    output logic              push_ok,
    output logic              drop
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("hps_spi_rx_fifo: FIFO_DEPTH must be a power of 2 and at least 2");
    end

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_nxt;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic              full;
    logic              pop;

    assign valid = (count != '0);

    // Push/pop arbitration and look-ahead of the head entry.
    always_comb begin
        full      = (count == FULL_CNT);
        pop       = valid & pop_req;
        push_ok   = push & (~full | pop);
        drop      = push & full & ~pop;
        rd_nxt    = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        // The slot about to become head may be the one written this cycle.
        head_nxt  = (push_ok && (wr_ptr == rd_nxt)) ? push_data : mem[rd_nxt];
        count_nxt = count + CNT_W'(push_ok) - CNT_W'(pop);
    end

    // Storage, pointers, occupancy and registered head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_nxt;
            count  <= count_nxt;
            head   <= head_nxt;
        end
    end

endmodule

// File: rtl/hps_spi_bridge.sv
// HPS<->FPGA SPI bridge: mode-0 SPI slave oversampled in sys_clk, RX words
// buffered in a FWFT FIFO, TX word resampled at every word boundary, and
// status packed into gp_out above the FIFO head.
module hps_spi_bridge
    import hps_if_pkg::*;
#(
    parameter int unsigned WORD_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned STATUS_W   = 3,
    parameter int unsigned GP_W       = GP_W_DEFAULT
) (
    input  logic                sys_clk,
    input  logic                reset_n,
    input  logic                spi_clk,
    input  logic                spi_cs,
    input  logic                spi_mosi,
    output logic                spi_miso,
    input  logic [WORD_W-1:0]   tx_data,
    output logic [WORD_W-1:0]   rx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic                io_strobe,
    output logic                frame_act,
    output logic                overflow,
    input  logic                ovf_clr,
    input  logic [STATUS_W-1:0] status,
    output logic [GP_W-1:0]     gp_out
);

    localparam int unsigned CNT_W         = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
    localparam int unsigned GP_STATUS_LSB = gp_status_lsb(WORD_W);
    localparam int unsigned GP_FRAME_BIT  = gp_frame_bit(WORD_W, STATUS_W);
    localparam int unsigned GP_OVF_BIT    = gp_ovf_bit(WORD_W, STATUS_W);

    if (WORD_W < 8) begin : g_chk_word
        $error("hps_spi_bridge: WORD_W must be at least 8");
    end
    if (WORD_W + STATUS_W + 2 > GP_W) begin : g_chk_gp
        $error("hps_spi_bridge: GP_W too small for WORD_W+STATUS_W+2");
    end

    logic [2:0]        clk_sync;
    logic [2:0]        cs_sync;
    logic [1:0]        mosi_sync;
    logic              rise_e, fall_e, cs_fall_e, cs_rise_e, mosi_s;

    logic [CNT_W-1:0]  bit_cnt, bit_nxt;
    logic [WORD_W-1:0] rx_sh, rx_sh_nxt;
    logic [WORD_W-1:0] tx_sh, tx_sh_nxt;
    logic              reload_pend, reload_nxt;
    logic              seen_rise, seen_nxt;
    logic              frame_nxt;
    logic              ovf_nxt;
    logic              push;
    logic [WORD_W-1:0] push_word;
    logic [GP_W-1:0]   gp_nxt;

    logic [WORD_W-1:0] head_nxt;
    logic              push_ok;
    logic              drop;

    // Two-flop synchronisers; the extra stage on clk/cs feeds edge detection.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync  <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
        end else begin
            clk_sync  <= {clk_sync[1:0], spi_clk};
            cs_sync   <= {cs_sync[1:0], spi_cs};
            mosi_sync <= {mosi_sync[0], spi_mosi};
        end
    end

    assign rise_e    =  clk_sync[1] & ~clk_sync[2];
    assign fall_e    = ~clk_sync[1] &  clk_sync[2];
    assign cs_fall_e = ~cs_sync[1]  &  cs_sync[2];
    assign cs_rise_e =  cs_sync[1]  & ~cs_sync[2];
    assign mosi_s    =  mosi_sync[1];
    assign push_word = {rx_sh[WORD_W-2:0], mosi_s};
    assign spi_miso  = frame_act & tx_sh[WORD_W-1];

    // Next-state for the SPI engine; computed combinationally so gp_out can
    // be registered alongside the state it mirrors.
    always_comb begin
        frame_nxt  = frame_act;
        bit_nxt    = bit_cnt;
        rx_sh_nxt  = rx_sh;
        tx_sh_nxt  = tx_sh;
        reload_nxt = reload_pend;
        seen_nxt   = seen_rise;
        push       = 1'b0;
        if (cs_fall_e) begin
            tx_sh_nxt  = tx_data;
            bit_nxt    = '0;
            frame_nxt  = 1'b1;
            reload_nxt = 1'b0;
            seen_nxt   = 1'b0;
        end else if (cs_rise_e) begin
            bit_nxt    = '0;
            frame_nxt  = 1'b0;
            reload_nxt = 1'b0;
            seen_nxt   = 1'b0;
        end else if (frame_act) begin
            if (rise_e) begin
                rx_sh_nxt = push_word;
                seen_nxt  = 1'b1;
                if (bit_cnt == LAST_BIT) begin
                    push       = 1'b1;
                    bit_nxt    = '0;
                    reload_nxt = 1'b1;
                end else begin
                    bit_nxt = bit_cnt + CNT_W'(1);
                end
            end else if (fall_e && seen_rise) begin
                // Mode 0: the MSB is already on MISO before the first rise.
                if (reload_pend) begin
                    tx_sh_nxt  = tx_data;
                    reload_nxt = 1'b0;
                end else begin
                    tx_sh_nxt = tx_sh << 1;
                end
            end
        end

        if (drop) begin
            ovf_nxt = 1'b1;
        end else if (ovf_clr) begin
            ovf_nxt = 1'b0;
        end else begin
            ovf_nxt = overflow;
        end

        gp_nxt                                = '0;
        gp_nxt[WORD_W-1:0]                    = head_nxt;
        gp_nxt[GP_STATUS_LSB +: STATUS_W]     = status;
        gp_nxt[GP_FRAME_BIT]                  = frame_nxt;
        gp_nxt[GP_OVF_BIT]                    = ovf_nxt;
    end

    // SPI engine state, sticky overflow, strobe and packed status register.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_act   <= 1'b0;
            bit_cnt     <= '0;
            rx_sh       <= '0;
            tx_sh       <= '0;
            reload_pend <= 1'b0;
            seen_rise   <= 1'b0;
            overflow    <= 1'b0;
            io_strobe   <= 1'b0;
            gp_out      <= '0;
        end else begin
            frame_act   <= frame_nxt;
            bit_cnt     <= bit_nxt;
            rx_sh       <= rx_sh_nxt;
            tx_sh       <= tx_sh_nxt;
            reload_pend <= reload_nxt;
            seen_rise   <= seen_nxt;
            overflow    <= ovf_nxt;
            io_strobe   <= push_ok;
            gp_out      <= gp_nxt;
        end
    end

    hps_spi_rx_fifo #(
        .WORD_W     (WORD_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (sys_clk),
        .rst_n     (reset_n),
        .push      (push),
        .push_data (push_word),
        .pop_req   (rx_ready),
        .head      (rx_data),
        .head_nxt  (head_nxt),
        .valid     (rx_valid),
        .push_ok   (push_ok),
        .drop      (drop)
    );

endmodule

// File: tb/tb_hps_spi_bridge.sv
// Directed bench for hps_spi_bridge: WORD_W=16, FIFO_DEPTH=4, STATUS_W=3,
// GP_W=32; spi_clk runs at sys_clk/10.
module tb_hps_spi_bridge;

    localparam int unsigned WORD_W     = 16;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned STATUS_W   = 3;
    localparam int unsigned GP_W       = 32;

    logic                sys_clk  = 1'b0;
    logic                reset_n  = 1'b0;
    logic                spi_clk  = 1'b0;
    logic                spi_cs   = 1'b1;
    logic                spi_mosi = 1'b0;
    logic                spi_miso;
    logic [WORD_W-1:0]   tx_data  = '0;
    logic [WORD_W-1:0]   rx_data;
    logic                rx_valid;
    logic                rx_ready = 1'b0;
    logic                io_strobe;
    logic                frame_act;
    logic                overflow;
    logic                ovf_clr  = 1'b0;
    logic [STATUS_W-1:0] status   = 3'b101;
    logic [GP_W-1:0]     gp_out;

    int vectors     = 0;
    int miscompares = 0;
    int strobe_cnt  = 0;

    always #5 sys_clk = ~sys_clk;

    hps_spi_bridge #(
        .WORD_W     (WORD_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .STATUS_W   (STATUS_W),
        .GP_W       (GP_W)
    ) dut (
        .sys_clk   (sys_clk),
        .reset_n   (reset_n),
        .spi_clk   (spi_clk),
        .spi_cs    (spi_cs),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .tx_data   (tx_data),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .io_strobe (io_strobe),
        .frame_act (frame_act),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr),
        .status    (status),
        .gp_out    (gp_out)
    );

    always @(negedge sys_clk) begin
        if (io_strobe === 1'b1) strobe_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // One SPI word (or its first nbits), MSB first, mode 0, half period 5 cycles.
    task automatic spi_xfer(input logic [15:0] mosi_w, input int nbits,
                            input bit change_tx, input logic [15:0] tx_next,
                            input bit pop_last, output logic [15:0] miso_w);
        miso_w = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = mosi_w[15-i];
            cycles(5);
            miso_w[15-i] = spi_miso;
            spi_clk = 1'b1;
            if (i == 15 && change_tx) tx_data = tx_next;
            if (i == 15 && pop_last) begin
                // rise_e is seen two sys edges after this; pop on the push edge.
                cycles(2);
                rx_ready = 1'b1;
                cycles(1);
                rx_ready = 1'b0;
                check("full_pushpop_strobe", io_strobe, 1'b1);
                cycles(2);
            end else begin
                cycles(5);
            end
            spi_clk = 1'b0;
        end
    endtask

    task automatic pop_check(input string tag, input logic [15:0] exp);
        check(tag, rx_valid, 1'b1);
        check(tag, rx_data, exp);
        rx_ready = 1'b1;
        cycles(1);
        rx_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] miso;
        int s0;

        // Reset state
        cycles(3);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_data", rx_data, 16'h0);
        check("rst_gp_out", gp_out, 32'h0);
        check("rst_miso", spi_miso, 1'b0);
        reset_n = 1'b1;
        cycles(5);

        // Reset asserted in the middle of a frame
        tx_data = 16'hFFFF;
        spi_cs  = 1'b0;
        cycles(10);
        spi_xfer(16'h0000, 5, 1'b0, 16'h0, 1'b0, miso);
        check("midframe_frame_act", frame_act, 1'b1);
        check("midframe_miso", spi_miso, 1'b1);
        reset_n = 1'b0;
        #1;
        check("async_rst_frame_act", frame_act, 1'b0);
        check("async_rst_miso", spi_miso, 1'b0);
        check("async_rst_gp_out", gp_out, 32'h0);
        check("async_rst_flags", {rx_valid, io_strobe, overflow}, 3'b000);
        cycles(1);
        spi_cs = 1'b1;
        cycles(3);
        reset_n = 1'b1;
        cycles(10);
        check("post_rst_frame_act", frame_act, 1'b0);
        check("post_rst_rx_valid", rx_valid, 1'b0);
        check("post_rst_miso", spi_miso, 1'b0);

        // Single word frame
        tx_data = 16'h1234;
        s0 = strobe_cnt;
        spi_cs = 1'b0;
        cycles(10);
        spi_xfer(16'hA5C3, 16, 1'b0, 16'h0, 1'b0, miso);
        check("w1_miso", miso, 16'h1234);
        cycles(2);
        check("w1_gp_in_frame", gp_out, 32'h000DA5C3);
        spi_cs = 1'b1;
        cycles(10);
        check("w1_strobes", strobe_cnt - s0, 1);
        check("w1_gp_idle", gp_out, 32'h0005A5C3);
        check("w1_miso_idle", spi_miso, 1'b0);
        pop_check("w1_pop", 16'hA5C3);
        check("w1_empty", rx_valid, 1'b0);

        // Three words in one frame, tx_data changed after word 1
        tx_data = 16'h1234;
        s0 = strobe_cnt;
        spi_cs = 1'b0;
        cycles(10);
        spi_xfer(16'h1111, 16, 1'b1, 16'hBEEF, 1'b0, miso);
        check("w3_miso_0", miso, 16'h1234);
        spi_xfer(16'h2222, 16, 1'b0, 16'h0, 1'b0, miso);
        check("w3_miso_1", miso, 16'hBEEF);
        spi_xfer(16'h3333, 16, 1'b0, 16'h0, 1'b0, miso);
        check("w3_miso_2", miso, 16'hBEEF);
        spi_cs = 1'b1;
        cycles(10);
        check("w3_strobes", strobe_cnt - s0, 3);
        pop_check("w3_pop0", 16'h1111);
        pop_check("w3_pop1", 16'h2222);
        pop_check("w3_pop2", 16'h3333);
        check("w3_empty", rx_valid, 1'b0);

        // Overflow: five words into a four-entry FIFO
        tx_data = 16'h0000;
        s0 = strobe_cnt;
        spi_cs = 1'b0;
        cycles(10);
        spi_xfer(16'hA001, 16, 1'b0, 16'h0, 1'b0, miso);
        spi_xfer(16'hA002, 16, 1'b0, 16'h0, 1'b0, miso);
        spi_xfer(16'hA003, 16, 1'b0, 16'h0, 1'b0, miso);
        spi_xfer(16'hA004, 16, 1'b0, 16'h0, 1'b0, miso);
        check("ovf_before_drop", overflow, 1'b0);
        spi_xfer(16'hA005, 16, 1'b0, 16'h0, 1'b0, miso);
        spi_cs = 1'b1;
        cycles(10);
        check("ovf_strobes", strobe_cnt - s0, 4);
        check("ovf_set", overflow, 1'b1);
        check("ovf_gp_out", gp_out, 32'h0015A001);
        ovf_clr = 1'b1;
        cycles(1);
        ovf_clr = 1'b0;
        check("ovf_cleared", overflow, 1'b0);

        // Push onto a full FIFO in the same cycle as a pop
        s0 = strobe_cnt;
        spi_cs = 1'b0;
        cycles(10);
        spi_xfer(16'hC006, 16, 1'b0, 16'h0, 1'b1, miso);
        spi_cs = 1'b1;
        cycles(10);
        check("full_pp_strobes", strobe_cnt - s0, 1);
        check("full_pp_overflow", overflow, 1'b0);
        pop_check("full_pp_pop0", 16'hA002);
        pop_check("full_pp_pop1", 16'hA003);
        pop_check("full_pp_pop2", 16'hA004);
        pop_check("full_pp_pop3", 16'hC006);
        check("full_pp_empty", rx_valid, 1'b0);

        // Partial word discarded on CS deassert, next frame intact
        s0 = strobe_cnt;
        spi_cs = 1'b0;
        cycles(10);
        spi_xfer(16'hFFFF, 9, 1'b0, 16'h0, 1'b0, miso);
        spi_cs = 1'b1;
        cycles(10);
        check("partial_strobes", strobe_cnt - s0, 0);
        check("partial_empty", rx_valid, 1'b0);
        check("partial_frame_act", frame_act, 1'b0);
        spi_cs = 1'b0;
        cycles(10);
        spi_xfer(16'h0F0F, 16, 1'b0, 16'h0, 1'b0, miso);
        spi_cs = 1'b1;
        cycles(10);
        check("after_partial_strobes", strobe_cnt - s0, 1);
        pop_check("after_partial_pop", 16'h0F0F);
        check("after_partial_empty", rx_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
